// File: rtl/cond_unit_if.sv
// Decoder/condition-unit bus: instruction controls in, gated enables,
// stored flags and instruction counters out.
interface cond_unit_if;
    logic        en;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic        NoWrite;
    logic        cnt_clr;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic        CondEx;
    logic [3:0]  Flags;
    logic [31:0] exec_count;
    logic [31:0] skip_count;

    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, cnt_clr,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_count, skip_count
    );

    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, cnt_clr,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_count, skip_count
    );
endinterface

// File: rtl/cond_unit.sv
// ARM-style condition unit: evaluates the condition field against the
// stored NZCV flags, gates the write enables, updates the flags and keeps
// executed/squashed instruction counters.
module cond_unit (
    input logic        clk,
    input logic        reset,
    cond_unit_if.slave bus
);

    logic [3:0]  flags_q;
    logic [31:0] exec_q;
    logic [31:0] skip_q;
    logic        cond_ex;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition decode works only on the stored flags; ALUFlags of the
    // current instruction are never bypassed into the decision.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign bus.CondEx     = cond_ex;
    assign bus.PCSrc      = bus.en & bus.PCS & cond_ex;
    assign bus.RegWrite   = bus.en & bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite   = bus.en & bus.MemW & cond_ex;
    assign bus.Flags      = flags_q;
    assign bus.exec_count = exec_q;
    assign bus.skip_count = skip_q;

    // Flag register: N,Z and C,V pairs load independently, only for a
    // valid instruction whose condition passed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (bus.en && cond_ex) begin
            if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Instruction counters; clear wins over counting, both wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q <= 32'd0;
            skip_q <= 32'd0;
        end else if (bus.cnt_clr) begin
            exec_q <= 32'd0;
            skip_q <= 32'd0;
        end else if (bus.en) begin
            if (cond_ex) exec_q <= exec_q + 32'd1;
            else         skip_q <= skip_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit: directed vectors with literal expectations plus
// a reference model compared against the DUT on every falling clock edge.
module tb_cond_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;

    cond_unit_if bus ();

    cond_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [3:0]  m_flags = 4'b0000;
    logic [31:0] m_exec = 32'd0;
    logic [31:0] m_skip = 32'd0;
    logic        m_pass;

    // ARM conditions come in complementary pairs: even code is the base
    // test, odd code its inverse; 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update mirrors the architectural rules at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags = 4'b0000;
            m_exec  = 32'd0;
            m_skip  = 32'd0;
        end else begin
            m_pass = cond_pass(bus.Cond, m_flags);
            if (bus.cnt_clr) begin
                m_exec = 32'd0;
                m_skip = 32'd0;
            end else if (bus.en) begin
                if (m_pass) m_exec = m_exec + 32'd1;
                else        m_skip = m_skip + 32'd1;
            end
            if (bus.en && m_pass) begin
                if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
                if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
            end
        end
    end

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        logic p;
        if (chk_on) begin
            p = cond_pass(bus.Cond, m_flags);
            chk("CondEx",   {31'd0, bus.CondEx},   {31'd0, p});
            chk("PCSrc",    {31'd0, bus.PCSrc},    {31'd0, bus.en & bus.PCS & p});
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, bus.en & bus.RegW & p & ~bus.NoWrite});
            chk("MemWrite", {31'd0, bus.MemWrite}, {31'd0, bus.en & bus.MemW & p});
            chk("Flags",    {28'd0, bus.Flags},    {28'd0, m_flags});
            chk("exec",     bus.exec_count,        m_exec);
            chk("skip",     bus.skip_count,        m_skip);
        end
    end

    task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic rw,
                         input logic mw, input logic nw, input logic clr);
        bus.en       = e;
        bus.Cond     = c;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.RegW     = rw;
        bus.MemW     = mw;
        bus.NoWrite  = nw;
        bus.cnt_clr  = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        #1;
        chk("rst_flags", {28'd0, bus.Flags}, 32'd0);
        chk("rst_exec",  bus.exec_count, 32'd0);
        chk("rst_skip",  bus.skip_count, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // EQ fails on cleared flags
        drive(1, 4'b0000, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        #1;
        chk("eq_pcsrc",  {31'd0, bus.PCSrc},  32'd0);
        chk("eq_condex", {31'd0, bus.CondEx}, 32'd0);
        tick();
        chk("eq_skip", bus.skip_count, 32'd1);
        chk("eq_exec", bus.exec_count, 32'd0);

        // AL sets Z, then EQ branches
        drive(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        tick();
        chk("al_flags", {28'd0, bus.Flags}, 32'h4);
        drive(1, 4'b0000, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        #1;
        chk("eq_branch", {31'd0, bus.PCSrc}, 32'd1);
        tick();

        // NE fails: flags must not be written
        drive(1, 4'b0001, 4'b1010, 2'b11, 0, 0, 0, 0, 0);
        #1;
        chk("ne_condex", {31'd0, bus.CondEx}, 32'd0);
        tick();
        chk("ne_flags", {28'd0, bus.Flags}, 32'h4);
        chk("ne_skip", bus.skip_count, 32'd2);

        // Short async reset pulse between edges, then N,Z-only update
        reset = 1'b0;
        #1 reset = 1'b1;
        drive(1, 4'b1110, 4'b1111, 2'b10, 0, 1, 0, 1, 0);
        #1;
        chk("nowrite_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        tick();
        chk("nz_flags", {28'd0, bus.Flags}, 32'hC);

        // Counter wrap from all-ones
        force dut.exec_q = 32'hFFFF_FFFF;
        m_exec = 32'hFFFF_FFFF;
        #1 release dut.exec_q;
        drive(1, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        tick();
        chk("wrap_exec", bus.exec_count, 32'd0);
        drive(1, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4'b1111, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        tick();
        chk("pre_clr_exec", bus.exec_count, 32'd1);
        chk("pre_clr_skip", bus.skip_count, 32'd1);
        drive(1, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1);
        tick();
        chk("clr_exec",  bus.exec_count, 32'd0);
        chk("clr_skip",  bus.skip_count, 32'd0);
        chk("clr_flags", {28'd0, bus.Flags}, 32'hC);

        // Full condition x flags sweep, model checks each cycle
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'b1110, f[3:0], 2'b11, 0, 0, 0, 0, 0);
            tick();
            for (int c = 0; c < 16; c++) begin
                drive(c[0] ^ f[0], c[3:0], ~f[3:0], 2'b00, 1, 1, 1, c[1], 0);
                tick();
            end
        end
        chk("sweep_flags", {28'd0, bus.Flags}, 32'hF);

        // en=0 freezes state and gates every enable
        drive(0, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 0);
        #1;
        chk("en0_gates", {29'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 32'd0);
        chk("en0_condex", {31'd0, bus.CondEx}, 32'd1);
        tick();
        chk("en0_flags", {28'd0, bus.Flags}, 32'hF);

        // Reset during a pending update discards it; first update after release
        drive(1, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 0);
        tick();
        chk("pre_rst_flags", {28'd0, bus.Flags}, 32'hA);
        drive(1, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_flags", {28'd0, bus.Flags}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        chk("held_rst_flags", {28'd0, bus.Flags}, 32'd0);
        tick();
        chk("post_rst_flags", {28'd0, bus.Flags}, 32'h5);
        chk("post_rst_exec", bus.exec_count, 32'd1);

        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, in, 1, asynchronous active-low reset (asserted when 0).
REQ-003 SHALL have port en, in, 1, instruction valid/advance; when 0 no state changes and all gated outputs are 0.
REQ-004 SHALL have port Cond, in, 4, ARM condition field of the current instruction.
REQ-005 SHALL have port ALUFlags, in, 4, {N,Z,C,V} produced by the ALU for the current instruction.
REQ-006 SHALL have port FlagW, in, 2, flag write request; bit1 = update N,Z; bit0 = update C,V.
REQ-007 SHALL have ports PCS, RegW, MemW, NoWrite, in, 1 each, decoder requests: branch/PC write, register write, memory write, suppress register write (CMP/CMN/TST/TEQ).
REQ-008 SHALL have port cnt_clr, in, 1, synchronous clear of both counters.
REQ-009 SHALL have ports PCSrc, RegWrite, MemWrite, out, 1 each, condition-gated write enables.
REQ-010 SHALL have port CondEx, out, 1, condition passed for the current instruction.
REQ-011 SHALL have port Flags, out, 4, stored {N,Z,C,V} register contents.
REQ-012 SHALL have ports exec_count and skip_count, out, 32 each, executed/squashed instruction counters.

Function
REQ-013 SHALL evaluate CondEx combinationally from Cond and the stored Flags (never from ALUFlags).
REQ-014 SHALL decode Cond: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-015 SHALL drive PCSrc = en & PCS & CondEx, with no cycle latency.
REQ-016 SHALL drive RegWrite = en & RegW & CondEx & ~NoWrite.
REQ-017 SHALL drive MemWrite = en & MemW & CondEx.
REQ-018 SHALL drive CondEx independent of en; the gated outputs alone reflect en.
REQ-019 SHALL, on a rising edge with en=1, CondEx=1, FlagW[1]=1, load Flags[3:2] from ALUFlags[3:2].
REQ-020 SHALL, on a rising edge with en=1, CondEx=1, FlagW[0]=1, load Flags[1:0] from ALUFlags[1:0].
REQ-021 SHALL hold each flag pair unchanged when its write condition is false, including failed-condition instructions with FlagW set.
REQ-022 SHALL make updated Flags visible to CondEx in the cycle after the update (one-cycle latency, no bypass from ALUFlags).
REQ-023 SHALL increment exec_count on a rising edge with en=1 and CondEx=1, and skip_count when en=1 and CondEx=0.
REQ-024 SHALL wrap both counters modulo 2^32 (0xFFFFFFFF -> 0x00000000), with no saturation or flag.
REQ-025 SHALL give cnt_clr priority over increment: with cnt_clr=1 both counters become 0 regardless of en/CondEx.
REQ-026 SHALL leave Flags unaffected by cnt_clr.

Reset
REQ-027 SHALL, while reset=0, force Flags=4'b0000, exec_count=0, skip_count=0 immediately, without waiting for clk.
REQ-028 SHALL, with Flags=0 after reset, give EQ/CS/MI/VS/HI/NV failing and NE/CC/PL/VC/LS/GE/AL passing; gated outputs follow per REQ-015..017.
REQ-029 SHALL, on reset asserted mid-cycle during an update, discard the update; the first update after release occurs at the first rising edge with reset=1.

Verification
REQ-030 Reset, then Cond=0000, en=1, PCS=1 -> PCSrc=0, CondEx=0; next edge skip_count=1, exec_count=0.
REQ-031 Cond=1110, FlagW=11, ALUFlags=0100, en=1 -> next cycle Flags=0100; then Cond=0000, PCS=1 -> PCSrc=1.
REQ-032 Flags=0100, Cond=0001, FlagW=11, ALUFlags=1010 -> CondEx=0, Flags stays 0100 after edge, skip_count increments.
REQ-033 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 after edge; RegW=1, NoWrite=1 -> RegWrite=0.
REQ-034 Preload exec_count to 0xFFFFFFFF via 2^32-1 passing instructions or force; one more AL instruction -> 0x00000000; cnt_clr=1 with en=1 simultaneously -> both counters 0.
REQ-035 Sweep all 16 Cond values against all 16 Flags values -> CondEx matches REQ-014 table in all 256 cases; en=0 -> PCSrc=RegWrite=MemWrite=0, no state change.
